// File: rtl/pdp_common_pkg.sv
// Shared PDP-8 definitions: data widths, opcode fields, group-7 micro-op
// words and the one-hot opcode structs passed from fetch/decode to execute.
package pdp_common_pkg;

  localparam int ADDR_WIDTH = 12;
  localparam int DATA_WIDTH = 12;

  localparam logic [2:0] OPC_AND = 3'o0;
  localparam logic [2:0] OPC_TAD = 3'o1;
  localparam logic [2:0] OPC_ISZ = 3'o2;
  localparam logic [2:0] OPC_DCA = 3'o3;
  localparam logic [2:0] OPC_JMS = 3'o4;
  localparam logic [2:0] OPC_JMP = 3'o5;
  localparam logic [2:0] OPC_IOT = 3'o6;
  localparam logic [2:0] OPC_OPR = 3'o7;

  typedef struct packed {
    logic and_op;
    logic tad;
    logic isz;
    logic dca;
    logic jms;
    logic jmp;
  } pdp_mem_opcode_s;

  // Field order fixes the bit index: nop is bit 21, cla2 is bit 0.
  typedef struct packed {
    logic nop;
    logic iac;
    logic ral;
    logic rtl;
    logic rar;
    logic rtr;
    logic cml;
    logic cma;
    logic cia;
    logic cll;
    logic cla1;
    logic cla_cll;
    logic hlt;
    logic osr;
    logic skp;
    logic snl;
    logic szl;
    logic sza;
    logic sna;
    logic sma;
    logic spa;
    logic cla2;
  } pdp_op7_opcode_s;

  localparam int NUM_OP7 = 22;

  localparam logic [11:0] OP7_NOP     = 12'o7000;
  localparam logic [11:0] OP7_IAC     = 12'o7001;
  localparam logic [11:0] OP7_RAL     = 12'o7004;
  localparam logic [11:0] OP7_RTL     = 12'o7006;
  localparam logic [11:0] OP7_RAR     = 12'o7010;
  localparam logic [11:0] OP7_RTR     = 12'o7012;
  localparam logic [11:0] OP7_CML     = 12'o7020;
  localparam logic [11:0] OP7_CMA     = 12'o7040;
  localparam logic [11:0] OP7_CIA     = 12'o7041;
  localparam logic [11:0] OP7_CLL     = 12'o7100;
  localparam logic [11:0] OP7_CLA1    = 12'o7200;
  localparam logic [11:0] OP7_CLA_CLL = 12'o7300;
  localparam logic [11:0] OP7_HLT     = 12'o7402;
  localparam logic [11:0] OP7_OSR     = 12'o7404;
  localparam logic [11:0] OP7_SKP     = 12'o7410;
  localparam logic [11:0] OP7_SNL     = 12'o7420;
  localparam logic [11:0] OP7_SZL     = 12'o7430;
  localparam logic [11:0] OP7_SZA     = 12'o7440;
  localparam logic [11:0] OP7_SNA     = 12'o7450;
  localparam logic [11:0] OP7_SMA     = 12'o7500;
  localparam logic [11:0] OP7_SPA     = 12'o7510;
  localparam logic [11:0] OP7_CLA2    = 12'o7600;

  // Listed in struct order, so OP7_CODES[i] lines up with struct bit i.
  localparam logic [NUM_OP7-1:0][11:0] OP7_CODES = {
    OP7_NOP, OP7_IAC, OP7_RAL, OP7_RTL, OP7_RAR, OP7_RTR,
    OP7_CML, OP7_CMA, OP7_CIA, OP7_CLL, OP7_CLA1, OP7_CLA_CLL,
    OP7_HLT, OP7_OSR, OP7_SKP, OP7_SNL, OP7_SZL, OP7_SZA,
    OP7_SNA, OP7_SMA, OP7_SPA, OP7_CLA2
  };

endpackage

// File: rtl/pdp8_ifd_decoder.sv
// Combinational PDP-8 instruction decoder: word plus current page bits in,
// one-hot opcode structs, effective base address and indirect flag out.
module pdp8_ifd_decoder
  import pdp_common_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] ir,
  input  logic [4:0]            pc_page,
  output pdp_mem_opcode_s       mem_opcode,
  output pdp_op7_opcode_s       op7_opcode,
  output logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  mem_indirect
);

  logic [2:0]         opcode;
  logic               is_mem;
  logic [NUM_OP7-1:0] op7_match;

  assign opcode = ir[DATA_WIDTH-1 -: 3];
  assign is_mem = ~(opcode[2] & opcode[1]);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OP7; gi++) begin : g_op7_match
      assign op7_match[gi] = (ir == OP7_CODES[gi]);
    end
  endgenerate

  always_comb begin
    mem_opcode   = '0;
    op7_opcode   = '0;
    base_addr    = '0;
    mem_indirect = 1'b0;
    case (opcode)
      OPC_AND: mem_opcode.and_op = 1'b1;
      OPC_TAD: mem_opcode.tad    = 1'b1;
      OPC_ISZ: mem_opcode.isz    = 1'b1;
      OPC_DCA: mem_opcode.dca    = 1'b1;
      OPC_JMS: mem_opcode.jms    = 1'b1;
      OPC_JMP: mem_opcode.jmp    = 1'b1;
      default: ;
    endcase
    if (is_mem) begin
      mem_indirect = ir[8];
      base_addr    = ir[7] ? {pc_page, ir[6:0]} : {5'b0, ir[6:0]};
    end else begin
      // IOT and unlisted operate words never match, so they fall through to NOP.
      op7_opcode     = pdp_op7_opcode_s'(op7_match);
      op7_opcode.nop = ~|op7_match[NUM_OP7-2:0];
    end
  end

endmodule

// File: rtl/pdp8_ifd.sv
// PDP-8 fetch/decode stage: fetches one word at PC, issues it decoded to
// execute as a one-cycle pulse, then waits for execute to hand back the PC.
module pdp8_ifd
  import pdp_common_pkg::pdp_mem_opcode_s, pdp_common_pkg::pdp_op7_opcode_s;
#(
  parameter int                    ADDR_WIDTH = pdp_common_pkg::ADDR_WIDTH,
  parameter int                    DATA_WIDTH = pdp_common_pkg::DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] START_PC   = 12'o0200
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  mem_rd_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_rd_valid,
  input  logic                  stall,
  input  logic [ADDR_WIDTH-1:0] PC_value,
  output pdp_mem_opcode_s       pdp_mem_opcode,
  output pdp_op7_opcode_s       pdp_op7_opcode,
  output logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  mem_indirect,
  output logic [ADDR_WIDTH-1:0] ifd_pc
);

  localparam logic [1:0] ST_FETCH     = 2'd0;
  localparam logic [1:0] ST_WAIT_MEM  = 2'd1;
  localparam logic [1:0] ST_ISSUE     = 2'd2;
  localparam logic [1:0] ST_WAIT_EXEC = 2'd3;

  logic [1:0]            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
  logic                  grace_reg, grace_next;
  logic                  mem_rd_req_reg, mem_rd_req_next;
  logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
  pdp_mem_opcode_s       mem_opcode_reg, mem_opcode_next;
  pdp_op7_opcode_s       op7_opcode_reg, op7_opcode_next;
  logic [ADDR_WIDTH-1:0] base_addr_reg, base_addr_next;
  logic                  mem_indirect_reg, mem_indirect_next;
  logic [ADDR_WIDTH-1:0] ifd_pc_reg, ifd_pc_next;

  pdp_mem_opcode_s       dec_mem_opcode;
  pdp_op7_opcode_s       dec_op7_opcode;
  logic [ADDR_WIDTH-1:0] dec_base_addr;
  logic                  dec_mem_indirect;

  // Decoding the incoming word directly lets the issue registers load on the
  // same edge that would capture IR, so issue lands one cycle after data.
  pdp8_ifd_decoder u_decoder (
    .ir           (mem_rd_data),
    .pc_page      (pc_reg[ADDR_WIDTH-1:7]),
    .mem_opcode   (dec_mem_opcode),
    .op7_opcode   (dec_op7_opcode),
    .base_addr    (dec_base_addr),
    .mem_indirect (dec_mem_indirect)
  );

  always_comb begin
    state_next        = state_reg;
    pc_next           = pc_reg;
    grace_next        = grace_reg;
    mem_rd_req_next   = 1'b0;
    mem_addr_next     = mem_addr_reg;
    mem_opcode_next   = '0;
    op7_opcode_next   = '0;
    base_addr_next    = base_addr_reg;
    mem_indirect_next = mem_indirect_reg;
    ifd_pc_next       = ifd_pc_reg;
    case (state_reg)
      ST_FETCH: begin
        // Request is raised on entry to FETCH; after reset it is raised here.
        if (mem_rd_req_reg) begin
          state_next = ST_WAIT_MEM;
        end else begin
          mem_rd_req_next = 1'b1;
          mem_addr_next   = pc_reg;
        end
      end
      ST_WAIT_MEM: begin
        if (mem_rd_valid) begin
          state_next        = ST_ISSUE;
          mem_opcode_next   = dec_mem_opcode;
          op7_opcode_next   = dec_op7_opcode;
          base_addr_next    = dec_base_addr;
          mem_indirect_next = dec_mem_indirect;
          ifd_pc_next       = pc_reg;
        end
      end
      ST_ISSUE: begin
        state_next = ST_WAIT_EXEC;
        grace_next = 1'b1;
      end
      ST_WAIT_EXEC: begin
        grace_next = 1'b0;
        if (!grace_reg && !stall) begin
          state_next      = ST_FETCH;
          pc_next         = PC_value;
          mem_rd_req_next = 1'b1;
          mem_addr_next   = PC_value;
        end
      end
      default: state_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_FETCH;
      pc_reg           <= START_PC;
      grace_reg        <= 1'b0;
      mem_rd_req_reg   <= 1'b0;
      mem_addr_reg     <= START_PC;
      mem_opcode_reg   <= '0;
      op7_opcode_reg   <= '0;
      base_addr_reg    <= '0;
      mem_indirect_reg <= 1'b0;
      ifd_pc_reg       <= START_PC;
    end else begin
      state_reg        <= state_next;
      pc_reg           <= pc_next;
      grace_reg        <= grace_next;
      mem_rd_req_reg   <= mem_rd_req_next;
      mem_addr_reg     <= mem_addr_next;
      mem_opcode_reg   <= mem_opcode_next;
      op7_opcode_reg   <= op7_opcode_next;
      base_addr_reg    <= base_addr_next;
      mem_indirect_reg <= mem_indirect_next;
      ifd_pc_reg       <= ifd_pc_next;
    end
  end

  assign mem_rd_req     = mem_rd_req_reg;
  assign mem_addr       = mem_addr_reg;
  assign pdp_mem_opcode = mem_opcode_reg;
  assign pdp_op7_opcode = op7_opcode_reg;
  assign base_addr      = base_addr_reg;
  assign mem_indirect   = mem_indirect_reg;
  assign ifd_pc         = ifd_pc_reg;

endmodule
